// File: rtl/reorder_release_buffer_if.sv
// ----------------------------------------------------------------------------
// reorder_release_buffer_if
//   Bundles the upstream tuple handshake and the downstream release handshake
//   of reorder_release_buffer.
//
//   Upstream  : in_valid, in_ready, in_data, in_serial, in_keep, in_done
//   Downstream: out_valid, out_ready, out_data, out_serial
//
//   Modports
//     master : the side that produces tuples and consumes released tuples
//              (the environment / testbench).
//     slave  : the buffer itself.
// ----------------------------------------------------------------------------
interface reorder_release_buffer_if #(
    parameter int DATA_W = 128
) ();
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [31:0]       in_serial;
    logic              in_keep;
    logic              in_done;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [31:0]       out_serial;

    modport master (
        output in_valid, in_data, in_serial, in_keep, in_done, out_ready,
        input  in_ready, out_valid, out_data, out_serial
    );

    modport slave (
        input  in_valid, in_data, in_serial, in_keep, in_done, out_ready,
        output in_ready, out_valid, out_data, out_serial
    );
endinterface

// File: rtl/reorder_release_buffer.sv
// ----------------------------------------------------------------------------
// reorder_release_buffer
//   Accepts tuples tagged with a 32-bit serial in any order and releases them
//   strictly in serial order. Tuples with keep=0 are placeholders: they only
//   advance the release order and are never presented downstream.
//
//   Ports
//     clk, resetn  : clock, synchronous active-low reset
//     bus          : tuple in / tuple out handshakes (slave modport)
//     next_serial  : serial currently awaited at the head
//     occupancy    : number of occupied storage slots
//     done         : sticky end-of-stream flag (state FINISHED)
//     o_state      : current FSM state, for observation
//
//   Handshake semantics (both sides): a transfer happens on a rising edge
//   where valid and ready are both 1. in_ready may depend combinationally on
//   in_serial; out_valid/out_data/out_serial are registered and hold stable
//   while out_valid=1 and out_ready=0.
// ----------------------------------------------------------------------------
module reorder_release_buffer #(
    parameter int          DATA_W       = 128,
    parameter int          DEPTH        = 16,
    parameter logic [31:0] START_SERIAL = 32'd0
) (
    input  logic                     clk,
    input  logic                     resetn,
    reorder_release_buffer_if.slave  bus,
    output logic [31:0]              next_serial,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     done,
    output logic [1:0]               o_state
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int OCC_W = IDX_W + 1;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_FINISHED = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [DEPTH-1:0]  r_occ;
    logic [DEPTH-1:0]  r_keep;
    logic [DATA_W-1:0] r_data   [DEPTH];
    logic [31:0]       r_serial [DEPTH];

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [31:0]       r_out_serial;
    logic [31:0]       r_next_serial;
    logic [OCC_W-1:0]  r_occupancy;

    logic [IDX_W-1:0]  w_in_idx;
    logic [IDX_W-1:0]  w_head_idx;
    logic [31:0]       w_window_dist;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_head_occ;
    logic              w_head_keep;
    logic              w_load;
    logic              w_discard;
    logic              w_release;

    assign w_in_idx      = bus.in_serial[IDX_W-1:0];
    assign w_head_idx    = r_next_serial[IDX_W-1:0];
    // Modular distance, so the window stays correct across the 32-bit wrap.
    assign w_window_dist = bus.in_serial - r_next_serial;
    assign w_in_ready    = (r_state == ST_RUN) && (w_window_dist < 32'(DEPTH))
                           && !r_occ[w_in_idx];
    assign w_accept      = bus.in_valid && w_in_ready;

    assign w_head_occ    = r_occ[w_head_idx];
    assign w_head_keep   = r_keep[w_head_idx];
    assign w_load        = w_head_occ && w_head_keep && (!r_out_valid || bus.out_ready);
    // Placeholders never touch the output register, so they retire even
    // while the downstream side is stalled.
    assign w_discard     = w_head_occ && !w_head_keep;
    assign w_release     = w_load || w_discard;

    // Occupied flags. An accepted slot is always empty and the head slot is
    // always occupied when released, so the set and clear never collide.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_occ <= '0;
        end else begin
            if (w_accept)  r_occ[w_in_idx]   <= 1'b1;
            if (w_release) r_occ[w_head_idx] <= 1'b0;
        end
    end

    // Slot payload storage; only meaningful while the slot is occupied.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_data[w_in_idx]   <= bus.in_data;
            r_serial[w_in_idx] <= bus.in_serial;
            r_keep[w_in_idx]   <= bus.in_keep;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_serial <= '0;
        end else if (w_load) begin
            r_out_valid  <= 1'b1;
            r_out_data   <= r_data[w_head_idx];
            r_out_serial <= r_serial[w_head_idx];
        end else if (bus.out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_next_serial <= START_SERIAL;
            r_occupancy   <= '0;
        end else begin
            if (w_release) r_next_serial <= r_next_serial + 32'd1;
            case ({w_accept, w_release})
                2'b10:   r_occupancy <= r_occupancy + OCC_W'(1);
                2'b01:   r_occupancy <= r_occupancy - OCC_W'(1);
                default: r_occupancy <= r_occupancy;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) r_state <= ST_RUN;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (bus.in_done) begin
                    if ((r_occupancy != '0) || r_out_valid) w_state_nxt = ST_DRAIN;
                    else                                    w_state_nxt = ST_FINISHED;
                end
            end
            ST_DRAIN: begin
                if ((r_occupancy == '0) && !r_out_valid) w_state_nxt = ST_FINISHED;
            end
            ST_FINISHED: w_state_nxt = ST_FINISHED;
            default:     w_state_nxt = ST_RUN;
        endcase
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign bus.out_serial = r_out_serial;
    assign next_serial    = r_next_serial;
    assign occupancy      = r_occupancy;
    assign done           = (r_state == ST_FINISHED);
    assign o_state        = r_state;
endmodule

// File: tb/tb_reorder_release_buffer.sv
module tb_reorder_release_buffer;
  localparam int          DATA_W = 64;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] START  = 32'hFFFF_FFFE;
  localparam int          W      = 32 + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  reorder_release_buffer_if #(.DATA_W(DATA_W)) bus ();

  logic [31:0] next_serial;
  logic [2:0]  occupancy;
  logic        done;
  logic [1:0]  state_dbg;

  reorder_release_buffer #(
    .DATA_W(DATA_W),
    .DEPTH(DEPTH),
    .START_SERIAL(START)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus),
    .next_serial(next_serial),
    .occupancy(occupancy),
    .done(done),
    .o_state(state_dbg)
  );

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_fail = 0;
  logic [W-1:0]      exp_q[$];
  logic [DATA_W:0]   pend[logic [31:0]];   // {keep, data} keyed by serial
  logic [31:0]       mdl_next;
  bit                rand_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Release-order model: everything from mdl_next upward that is present
  // retires in serial order; kept tuples become expected outputs.
  task automatic mdl_accept(input logic [31:0] s, input logic k, input logic [DATA_W-1:0] d);
    logic [DATA_W:0] e;
    pend[s] = {k, d};
    while (pend.exists(mdl_next)) begin
      e = pend[mdl_next];
      if (e[DATA_W]) exp_q.push_back({mdl_next, e[DATA_W-1:0]});
      pend.delete(mdl_next);
      mdl_next = mdl_next + 32'd1;
    end
  endtask

  // Monitor: whatever is presented must be the oldest expected tuple.
  always @(negedge clk) begin
    if (resetn && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got serial %0h expected none at %0t", bus.out_serial, $time);
      end else begin
        check("out_serial", bus.out_serial, exp_q[0][W-1:DATA_W]);
        check("out_data", bus.out_data, exp_q[0][DATA_W-1:0]);
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    exp_q.delete();
    pend.delete();
    mdl_next = START;
    resetn = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_done = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic send(input logic [31:0] s, input logic k, output bit ok);
    logic [DATA_W-1:0] d;
    int n;
    d = {$urandom, $urandom};
    n = 0;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_serial = s;
    bus.in_keep = k;
    bus.in_data = d;
    @(negedge clk);
    while (!bus.in_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (bus.in_ready) begin
      mdl_accept(s, k, d);
      ok = 1'b1;
      @(posedge clk);
      #1;
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready 0 expected 1 for serial %0h", s);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!(occupancy == 3'd0 && !bus.out_valid) && n < 500) begin
      n++;
      @(negedge clk);
    end
    check(name, (occupancy == 3'd0 && !bus.out_valid), 1);
    check({name, "_sb_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    logic [31:0] base;
    logic [31:0] blk[4];
    logic [31:0] t;
    int j;

    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_serial = '0;
    bus.in_keep = 1'b0;
    bus.in_done = 1'b0;
    bus.out_ready = 1'b0;
    rand_done = 1'b0;
    do_reset();

    // Reset state
    bus.in_serial = START;
    @(negedge clk);
    check("rst_occupancy", occupancy, 0);
    check("rst_next_serial", next_serial, START);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_serial", bus.out_serial, 0);
    check("rst_done", done, 0);
    check("rst_in_ready", bus.in_ready, 1);
    tick();

    // Wrap-around release order
    bus.out_ready = 1'b1;
    send(32'hFFFF_FFFF, 1'b1, ok);
    send(32'hFFFF_FFFE, 1'b1, ok);
    send(32'h0000_0000, 1'b1, ok);
    send(32'h0000_0001, 1'b1, ok);
    wait_idle("wrap_idle");
    check("wrap_next_serial", next_serial, 32'd2);
    tick();

    // Out-of-order 3,1,2,0: consecutive release and head latency
    base = mdl_next;
    send(base + 32'd3, 1'b1, ok);
    send(base + 32'd1, 1'b1, ok);
    send(base + 32'd2, 1'b1, ok);
    send(base, 1'b1, ok);
    @(negedge clk);
    check("lat_not_yet", bus.out_valid, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("ooo_valid", bus.out_valid, 1);
      check("ooo_serial", bus.out_serial, base + 32'(i));
    end
    wait_idle("ooo_idle");
    tick();

    // Discarded keep=0 tuple in the middle
    base = mdl_next;
    send(base + 32'd3, 1'b1, ok);
    send(base + 32'd2, 1'b1, ok);
    send(base + 32'd1, 1'b0, ok);
    send(base, 1'b1, ok);
    wait_idle("ph_idle");
    check("ph_next_serial", next_serial, base + 32'd4);
    check("ph_occupancy", occupancy, 0);
    tick();

    // Window limit
    base = mdl_next;
    bus.out_ready = 1'b0;
    send(base + 32'd1, 1'b1, ok);
    send(base + 32'd2, 1'b1, ok);
    send(base + 32'd3, 1'b1, ok);
    bus.in_serial = base + 32'd4;
    repeat (3) begin
      @(negedge clk);
      check("window_block", bus.in_ready, 0);
    end
    tick();
    send(base, 1'b1, ok);
    send(base + 32'd4, 1'b1, ok);
    check("window_accept", ok, 1);
    @(negedge clk);
    check("window_occupancy", occupancy, 4);
    check("window_out_valid", bus.out_valid, 1);
    tick();
    bus.out_ready = 1'b1;
    wait_idle("window_idle");
    tick();

    // Downstream stall with 3 tuples
    base = mdl_next;
    bus.out_ready = 1'b0;
    send(base, 1'b1, ok);
    send(base + 32'd1, 1'b1, ok);
    send(base + 32'd2, 1'b1, ok);
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", bus.out_valid, 1);
    end
    check("stall_occupancy", occupancy, 2);
    tick();
    bus.out_ready = 1'b1;
    wait_idle("stall_idle");
    tick();

    // Randomized blocks of shuffled serials with random keep and backpressure
    base = mdl_next;
    rand_done = 1'b0;
    fork
      begin
        for (int b = 0; b < 30; b++) begin
          for (int i = 0; i < 4; i++) blk[i] = base + 32'(4 * b + i);
          for (int i = 3; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = blk[i];
            blk[i] = blk[j];
            blk[j] = t;
          end
          for (int i = 0; i < 4; i++) send(blk[i], ($urandom_range(0, 3) != 0), ok);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    wait_idle("rand_idle");
    check("rand_next_serial", next_serial, base + 32'd120);
    tick();

    // End of stream with 2 tuples pending
    base = mdl_next;
    bus.out_ready = 1'b0;
    send(base, 1'b1, ok);
    send(base + 32'd1, 1'b1, ok);
    bus.in_serial = base + 32'd2;
    bus.in_done = 1'b1;
    tick();
    @(negedge clk);
    check("drain_in_ready", bus.in_ready, 0);
    check("drain_done", done, 0);
    bus.out_ready = 1'b1;
    wait_idle("drain_idle");
    check("drain_done_late", done, 0);
    @(negedge clk);
    check("finished_done", done, 1);
    check("finished_in_ready", bus.in_ready, 0);
    check("finished_out_valid", bus.out_valid, 0);
    tick();
    do_reset();
    @(negedge clk);
    check("reset_done", done, 0);
    check("reset_occupancy", occupancy, 0);
    check("reset_next_serial", next_serial, START);
    tick();

    // Reset mid-operation discards stored and pending output
    bus.out_ready = 1'b0;
    send(START + 32'd1, 1'b1, ok);
    send(START, 1'b1, ok);
    send(START + 32'd2, 1'b1, ok);
    do_reset();
    @(negedge clk);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_occupancy", occupancy, 0);
    tick();
    bus.out_ready = 1'b1;
    send(START, 1'b1, ok);
    wait_idle("midrst_idle");
    check("midrst_next_serial", next_serial, START + 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
